// File: rtl/dadda_mult_pipe.sv
// Pipelined signed/unsigned multiplier on a Dadda reduction tree with valid/ready handshakes.
// Optional handshake counter (op_count, stats_clr) is compiled in when DADDA_MULT_STATS_EN is defined.
module dadda_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
`ifdef DADDA_MULT_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [15:0]        op_count
`endif
);

  localparam int PW   = 2 * WIDTH;
  localparam int MAXH = WIDTH + 2;

  logic [PIPE_STAGES-1:0] vld;
  logic                   adv;
  logic [PW-1:0]          row0_c;
  logic [PW-1:0]          row1_c;

  function automatic int dadda_height(input int s);
    case (s)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 9;
      5:       return 13;
      6:       return 19;
      default: return 28;
    endcase
  endfunction

  // Builds the (Baugh-Wooley when sm=1) bit matrix and reduces it to two rows.
  // The mode only flips the MSB-row/column bits and gates the two constant ones,
  // so the same tree shape serves both signed and unsigned products.
  function automatic void reduce_rows(input  logic [WIDTH-1:0] x,
                                      input  logic [WIDTH-1:0] y,
                                      input  logic             sm,
                                      output logic [PW-1:0]    r0,
                                      output logic [PW-1:0]    r1);
    logic cur [PW][MAXH];
    logic nxt [PW][MAXH];
    int   h   [PW];
    int   nh  [PW];
    int   d;
    int   idx;
    int   rem;
    logic inv;

    for (int c = 0; c < PW; c++) begin
      h[c] = 0;
      for (int k = 0; k < MAXH; k++) cur[c][k] = 1'b0;
    end

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        inv = sm & ((i == WIDTH-1) != (j == WIDTH-1));
        cur[i+j][h[i+j]] = (x[j] & y[i]) ^ inv;
        h[i+j]++;
      end
    end
    cur[WIDTH][h[WIDTH]] = sm;
    h[WIDTH]++;
    cur[PW-1][h[PW-1]] = sm;
    h[PW-1]++;

    for (int s = 7; s >= 0; s--) begin
      d = dadda_height(s);
      if (d < WIDTH) begin
        for (int c = 0; c < PW; c++) begin
          nh[c] = 0;
          for (int k = 0; k < MAXH; k++) nxt[c][k] = 1'b0;
        end
        // Carries from column c land in column c+1 before c+1 is examined,
        // so each column's excess already accounts for incoming carries.
        for (int c = 0; c < PW; c++) begin
          idx = 0;
          for (int t = 0; t < MAXH; t++) begin
            rem = h[c] - idx;
            if ((rem + nh[c] - d >= 2) && (rem >= 3)) begin
              nxt[c][nh[c]] = cur[c][idx] ^ cur[c][idx+1] ^ cur[c][idx+2];
              nh[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][nh[c+1]] = (cur[c][idx] & cur[c][idx+1]) |
                                    (cur[c][idx] & cur[c][idx+2]) |
                                    (cur[c][idx+1] & cur[c][idx+2]);
                nh[c+1]++;
              end
              idx = idx + 3;
            end else if ((rem + nh[c] - d >= 1) && (rem >= 2)) begin
              nxt[c][nh[c]] = cur[c][idx] ^ cur[c][idx+1];
              nh[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][nh[c+1]] = cur[c][idx] & cur[c][idx+1];
                nh[c+1]++;
              end
              idx = idx + 2;
            end
          end
          for (int k = 0; k < MAXH; k++) begin
            if ((k >= idx) && (k < h[c])) begin
              nxt[c][nh[c]] = cur[c][k];
              nh[c]++;
            end
          end
        end
        cur = nxt;
        h   = nh;
      end
    end

    for (int c = 0; c < PW; c++) begin
      r0[c] = cur[c][0];
      r1[c] = cur[c][1];
    end
  endfunction

  // Reduction tree sits in front of the first register rank.
  always_comb begin
    row0_c = '0;
    row1_c = '0;
    reduce_rows(a, b, signed_mode, row0_c, row1_c);
  end

  assign out_valid = vld[PIPE_STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Global stall: every rank's valid bit shifts only when the output can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int k = 1; k < PIPE_STAGES; k++) vld[k] <= vld[k-1];
    end
  end

  if (PIPE_STAGES == 1) begin : g_single
    logic [PW-1:0] prod_q;

    // Single rank: the carry-propagate add runs straight into the output register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
      end else if (adv && in_valid) begin
        prod_q <= row0_c + row1_c;
      end
    end

    assign p = prod_q;
  end else begin : g_multi
    logic [PW-1:0] row0_q;
    logic [PW-1:0] row1_q;
    logic [PW-1:0] prod_q [PIPE_STAGES-1];

    // Rank 1 holds the two reduced rows, rank 2 the summed product, later ranks delay it.
    // Data only loads behind a valid bit so p keeps its last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        row0_q <= '0;
        row1_q <= '0;
        for (int k = 0; k < PIPE_STAGES-1; k++) prod_q[k] <= '0;
      end else if (adv) begin
        if (in_valid) begin
          row0_q <= row0_c;
          row1_q <= row1_c;
        end
        if (vld[0]) prod_q[0] <= row0_q + row1_q;
        for (int k = 1; k < PIPE_STAGES-1; k++) begin
          if (vld[k]) prod_q[k] <= prod_q[k-1];
        end
      end
    end

    assign p = prod_q[PIPE_STAGES-2];
  end

`ifdef DADDA_MULT_STATS_EN
  // Counts completed output handshakes; a clear wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= 16'd0;
    end else if (stats_clr) begin
      op_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
